// File: rtl/five_input_scan_sequencer.sv
// Scan sequencer for the five-input select mux: steps `s` through the enabled inputs and
// gathers the sampled `f_in` values into `word`. Define SCAN_PARITY_EN to add `word_parity`.
module five_input_scan_sequencer #(
    parameter int unsigned DWELL  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       continuous,
    input  logic [4:0] mask,
    input  logic       f_in,
    output logic [2:0] s,
    output logic       sel_valid,
    output logic       busy,
    output logic [4:0] word,
    output logic       word_valid
`ifdef SCAN_PARITY_EN
    ,
    output logic       word_parity
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    localparam logic [7:0] CNT_LAST   = 8'(DWELL - 1);
    localparam logic [7:0] CNT_SETTLE = 8'(SETTLE);

    // Any enabled input at index >= from_idx?
    function automatic logic has_set_from(input logic [4:0] m, input logic [2:0] from_idx);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            found = found | (m[i] & (i >= int'(from_idx)));
        end
        return found;
    endfunction

    // Lowest enabled index >= from_idx (0 when none; callers check has_set_from first).
    function automatic logic [2:0] first_set_from(input logic [4:0] m, input logic [2:0] from_idx);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (m[i] && (i >= int'(from_idx))) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic parity5(input logic [4:0] v);
        return ^v;
    endfunction

    logic [0:0] state_r;
    logic [7:0] cnt_r;
    logic [4:0] mask_r;
    logic [4:0] shadow_r;
    logic [2:0] s_r;
    logic       sel_valid_r;
    logic       busy_r;
    logic [4:0] word_r;
    logic       word_valid_r;
    logic       parity_r;

    logic [0:0] state_s;
    logic [7:0] cnt_s;
    logic [4:0] mask_s;
    logic [4:0] shadow_s;
    logic [4:0] sample_s;
    logic [2:0] s_s;
    logic [4:0] word_s;
    logic       word_valid_s;
    logic       scan_s;

    // Shadow with this cycle's sample merged in, so a sample on the last dwell cycle still lands in word.
    always_comb begin
        sample_s = shadow_r;
        if ((state_r == ST_SCAN) && (cnt_r == CNT_SETTLE)) begin
            sample_s[s_r] = f_in;
        end else begin
            sample_s = shadow_r;
        end
    end

    // Next-state logic for the IDLE/SCAN sequencer.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        mask_s       = mask_r;
        shadow_s     = shadow_r;
        s_s          = s_r;
        word_s       = word_r;
        word_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort && (mask != 5'b00000)) begin
                    state_s  = ST_SCAN;
                    mask_s   = mask;
                    s_s      = first_set_from(mask, 3'd0);
                    cnt_s    = 8'd0;
                    shadow_s = 5'b00000;
                end else begin
                    s_s = 3'd0;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    // Abort outranks pass completion; partial samples are dropped.
                    state_s  = ST_IDLE;
                    s_s      = 3'd0;
                    cnt_s    = 8'd0;
                    shadow_s = 5'b00000;
                end else if (cnt_r == CNT_LAST) begin
                    if (has_set_from(mask_r, s_r + 3'd1)) begin
                        s_s      = first_set_from(mask_r, s_r + 3'd1);
                        cnt_s    = 8'd0;
                        shadow_s = sample_s;
                    end else begin
                        word_s       = sample_s & mask_r;
                        word_valid_s = 1'b1;
                        cnt_s        = 8'd0;
                        shadow_s     = 5'b00000;
                        if (continuous && (mask != 5'b00000)) begin
                            mask_s = mask;
                            s_s    = first_set_from(mask, 3'd0);
                        end else begin
                            state_s = ST_IDLE;
                            s_s     = 3'd0;
                        end
                    end
                end else begin
                    cnt_s    = cnt_r + 8'd1;
                    shadow_s = sample_s;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                s_s      = 3'd0;
                cnt_s    = 8'd0;
                shadow_s = 5'b00000;
            end
        endcase
    end

    assign scan_s = (state_s == ST_SCAN);

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 8'd0;
            mask_r       <= 5'b00000;
            shadow_r     <= 5'b00000;
            s_r          <= 3'd0;
            sel_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            word_r       <= 5'b00000;
            word_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            mask_r       <= mask_s;
            shadow_r     <= shadow_s;
            s_r          <= s_s;
            sel_valid_r  <= scan_s;
            busy_r       <= scan_s;
            word_r       <= word_s;
            word_valid_r <= word_valid_s;
        end
    end

    // Parity tracks word and only moves when a new word is published.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_r <= 1'b0;
        end else if (word_valid_s) begin
            parity_r <= parity5(word_s);
        end else begin
            parity_r <= parity_r;
        end
    end

    assign s          = s_r;
    assign sel_valid  = sel_valid_r;
    assign busy       = busy_r;
    assign word       = word_r;
    assign word_valid = word_valid_r;

`ifdef SCAN_PARITY_EN
    assign word_parity = parity_r;
`else
    logic parity_unused_s;
    assign parity_unused_s = parity_r;
`endif

endmodule

// File: doc/five_input_scan_sequencer.md
Name: five_input_scan_sequencer

Overview:
Upstream control stage for the five-input select mux.
- Drives the 3-bit mux select `s` through the enabled inputs in turn, holding each select for a programmable number of cycles.
- Samples the mux output `f` back on `f_in` once it has settled, and assembles the five samples into a parallel word with a one-cycle valid strobe.
- Used to scan five status lines through a single observed path.

Parameters:
- DWELL, 4: cycles each select value is held. Legal range 2..255.
- SETTLE, 1: cycle index within a dwell at which `f_in` is sampled. Must satisfy 0 <= SETTLE < DWELL.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a scan pass; sampled only in IDLE.
- abort  input  1  terminate the scan; takes effect at the next edge.
- continuous  input  1  when 1 at the end of a pass, the next pass begins immediately.
- mask  input  5  input enable; bit i enables select value i (bit 0 = a, bit 4 = e). Latched on start.
- f_in  input  1  mux output being sampled.
- s  output  3  select to the mux, registered. Values 0..4 only.
- sel_valid  output  1  high while `s` addresses an enabled input being scanned.
- busy  output  1  high in SCAN.
- word  output  5  last completed sample word; bit i = sample taken at s=i.
- word_valid  output  1  one-cycle pulse when `word` updates.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - s=0, sel_valid=0, busy=0, word=5'b00000, word_valid=0.
  - State IDLE; dwell counter, latched mask and sample shadow all cleared.
  - Reset asserted mid-scan aborts the scan with no word_valid.
- Two states, IDLE and SCAN; an 8-bit dwell counter `cnt`.
- IDLE:
  - s=0, sel_valid=0.
  - start=1 and abort=0 and mask!=0 → latch mask, s=lowest set bit index, cnt=0, clear shadow, go to SCAN.
  - start with mask==0 is ignored.
  - start and abort in the same cycle: abort wins, stay in IDLE.
- SCAN:
  - busy=1, sel_valid=1, cnt increments each cycle.
  - When cnt==SETTLE, register f_in into shadow[s].
  - When cnt==DWELL-1:
    - If a higher enabled index exists, s = next enabled index, cnt=0.
    - Otherwise, pass complete: word=shadow (disabled bits forced to 0), word_valid=1 next cycle.
  - At pass complete with continuous=1: re-latch the current mask (if mask==0, go to IDLE), s=lowest enabled, cnt=0, and stay in SCAN. No idle gap between passes.
  - At pass complete with continuous=0: go to IDLE.
  - `continuous` is only examined at pass completion. Deasserting it mid-pass finishes the current pass.
- abort=1 in SCAN → IDLE at the next edge.
  - No word_valid; word retains its previous value; partial samples are discarded.
  - abort has priority over pass completion in the same cycle.
- start while busy is ignored. mask changes while busy have no effect until the next latch point.
- Timing: with N enabled inputs and start sampled at edge E0, word_valid is high in the cycle after edge E0 + N*DWELL.
- `s` is stable for exactly DWELL cycles per enabled input.
- `s` never takes values 5..7.

Optional Feature:
- Macro: SCAN_PARITY_EN.
- Defined: adds output `word_parity` (1 bit), registered together with word and equal to XOR of the 5 bits of word. Reset value 0, updated only when word_valid pulses.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
All scenarios use DWELL=4 and SETTLE=1, with a behavioural 5:1 mux model feeding `f_in` from `s` and {e,d,c,b,a}.
- Reset: assert rst asynchronously mid-cycle → s=0, busy=0, word=0, word_valid=0 immediately, with no clock edge required.
- Full pass: mask=5'b11111, {e,d,c,b,a}=5'b10110, start pulsed 1 cycle, continuous=0 →
  - s holds 0,1,2,3,4 for 4 cycles each;
  - word_valid is a single pulse 20 edges after start with word=5'b10110;
  - busy drops the same edge.
- Sparse mask: mask=5'b10101, inputs=5'b11111 →
  - s visits only 0,2,4;
  - word_valid after 12 edges with word=5'b10101.
- Continuous mode: mask=5'b00011, continuous=1, inputs=5'b00001, then 5'b00010 after the first pulse →
  - word_valid every 8 cycles, giving word=00001 then 00010;
  - deassert continuous mid-pass → that pass completes, then IDLE.
- Abort mid-scan: abort at cnt=2 while s=2 →
  - busy=0 and sel_valid=0 at the next edge;
  - no word_valid, word unchanged.
- Start and abort together in IDLE → stays IDLE.
- Start with mask=0 → no activity.
- Parity (SCAN_PARITY_EN defined): full pass with inputs=5'b10110 → word_parity=1 alongside word_valid.
